// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (port 0)
// and the debug/DMA port (port 1), with bounded locked bursts and 1-cycle read return.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

// state | meaning
// IDLE  | round-robin arbitration between both ports
// OWN0  | port 0 holds a locked burst; only port 0 may be granted
// OWN1  | port 1 holds a locked burst; only port 1 may be granted
module data_memory_arbiter #(
    parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
    parameter int DATA_SIZE    = `DATA_SIZE,
    parameter int MAX_BURST    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic                    lock0,
    input  logic                    lock1,
    input  logic [ADDRESS_SIZE-1:0] addr0,
    input  logic [ADDRESS_SIZE-1:0] addr1,
    input  logic [DATA_SIZE-1:0]    wdata0,
    input  logic [DATA_SIZE-1:0]    wdata1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    rvalid0,
    output logic                    rvalid1,
    output logic [DATA_SIZE-1:0]    rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [DATA_SIZE-1:0]    mem_data_in,
    input  logic [DATA_SIZE-1:0]    mem_data_out
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam bit         LOCK_EN     = (MAX_BURST > 1);
    localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

    state_t     state, next_state;
    logic       prio, next_prio;
    logic [4:0] cnt, next_cnt;
    logic [4:0] cnt_inc;

    assign cnt_inc = cnt + 5'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            prio    <= 1'b0;
            cnt     <= 5'd0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= next_state;
            prio    <= next_prio;
            cnt     <= next_cnt;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        next_state = state;
        next_prio  = prio;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || !prio)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
                // priority passes to whichever port did not just win
                if (gnt0 || gnt1) begin
                    next_prio = gnt0;
                end
                if (LOCK_EN && gnt0 && lock0) begin
                    next_state = OWN0;
                    next_cnt   = 5'd1;
                end else if (LOCK_EN && gnt1 && lock1) begin
                    next_state = OWN1;
                    next_cnt   = 5'd1;
                end
            end
            OWN0: begin
                gnt0 = req0;
                if (gnt0) begin
                    next_cnt = cnt_inc;
                end
                if (!lock0 || (gnt0 && cnt_inc == BURST_LIMIT)) begin
                    next_state = IDLE;
                    next_prio  = 1'b1;
                    next_cnt   = 5'd0;
                end
            end
            OWN1: begin
                gnt1 = req1;
                if (gnt1) begin
                    next_cnt = cnt_inc;
                end
                if (!lock1 || (gnt1 && cnt_inc == BURST_LIMIT)) begin
                    next_state = IDLE;
                    next_prio  = 1'b0;
                    next_cnt   = 5'd0;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 5'd0;
            end
        endcase
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // with no grant the address/data lines default to port 0
    assign mem_address = gnt1 ? addr1  : addr0;
    assign mem_data_in = gnt1 ? wdata1 : wdata0;
    assign mem_write   = (gnt0 & we0)  | (gnt1 & we1);
    assign mem_read    = (gnt0 & ~we0) | (gnt1 & ~we1);
    assign rdata       = mem_data_out;

endmodule
